// File: rtl/al_bky_word_sequencer_if.sv
// Handshake bundle between the auto-load word sequencer, its START/status
// controller, the BPI readback path and the Buckeye auto-load shifter.
interface al_bky_word_sequencer_if;
    logic        START;
    logic        BPI_RD_REQ;
    logic        BPI_DATA_VLD;
    logic [15:0] BPI_DATA;
    logic        AL_DONE;
    logic        CAPTURE;
    logic [15:0] BPI_AL_REG;
    logic        CLR_AL_DONE;
    logic        BUSY;
    logic        AL_OK;
    logic [2:0]  AL_ERR;
    logic [10:0] WORD_CNT;

    modport master (
        input  START, BPI_DATA_VLD, BPI_DATA, AL_DONE,
        output BPI_RD_REQ, CAPTURE, BPI_AL_REG, CLR_AL_DONE,
        output BUSY, AL_OK, AL_ERR, WORD_CNT
    );

    modport slave (
        output START, BPI_DATA_VLD, BPI_DATA, AL_DONE,
        input  BPI_RD_REQ, CAPTURE, BPI_AL_REG, CLR_AL_DONE,
        input  BUSY, AL_OK, AL_ERR, WORD_CNT
    );
endinterface

// File: rtl/al_bky_word_sequencer.sv
// Fetches a config image over BPI, checks header and XOR checksum, streams the
// payload into the Buckeye auto-load FIFO and handshakes the loader's DONE.
module al_bky_word_sequencer #(
    parameter logic [15:0] N_WORDS  = 16'd36,
    parameter logic [15:0] HDR_WORD = 16'hBC0A,
    parameter logic [23:0] TMO_CYC  = 24'd2000000
) (
    input  logic                           CLK40,
    input  logic                           RST_N,
    al_bky_word_sequencer_if.master        bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_HDR   = 3'd2,
        ST_DATA  = 3'd3,
        ST_CSUM  = 3'd4,
        ST_WAIT  = 3'd5,
        ST_CLEAR = 3'd6
    } state_e;

    localparam logic [10:0] LAST_WORD = N_WORDS[10:0] - 11'd1;
    localparam logic [23:0] TMO_LAST  = TMO_CYC - 24'd1;

    state_e      state_q;
    logic        rd_req_q;
    logic        capture_q;
    logic [15:0] al_reg_q;
    logic        clr_q;
    logic        ok_q;
    logic [2:0]  err_q;
    logic [10:0] cnt_q;
    logic [15:0] acc_q;
    logic [23:0] tmr_q;

    // Sequencer FSM; every strobe is raised on the transition into the cycle it belongs to.
    always_ff @(posedge CLK40) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            rd_req_q  <= 1'b0;
            capture_q <= 1'b0;
            al_reg_q  <= 16'd0;
            clr_q     <= 1'b0;
            ok_q      <= 1'b0;
            err_q     <= 3'd0;
            cnt_q     <= 11'd0;
            acc_q     <= 16'd0;
            tmr_q     <= 24'd0;
        end else begin
            rd_req_q  <= 1'b0;
            capture_q <= 1'b0;
            clr_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.START) begin
                        state_q  <= ST_REQ;
                        rd_req_q <= 1'b1;
                        ok_q     <= 1'b0;
                        err_q    <= 3'd0;
                        cnt_q    <= 11'd0;
                        acc_q    <= 16'd0;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    state_q <= ST_HDR;
                end
                ST_HDR: begin
                    if (bus.BPI_DATA_VLD) begin
                        if (bus.BPI_DATA == HDR_WORD) begin
                            state_q <= ST_DATA;
                        end else begin
                            err_q   <= 3'd1;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        state_q <= ST_HDR;
                    end
                end
                ST_DATA: begin
                    if (bus.BPI_DATA_VLD) begin
                        capture_q <= 1'b1;
                        al_reg_q  <= bus.BPI_DATA;
                        acc_q     <= acc_q ^ bus.BPI_DATA;
                        cnt_q     <= cnt_q + 11'd1;
                        if (cnt_q == LAST_WORD) begin
                            state_q <= ST_CSUM;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end else begin
                        state_q <= ST_DATA;
                    end
                end
                ST_CSUM: begin
                    if (bus.BPI_DATA_VLD) begin
                        if (bus.BPI_DATA == acc_q) begin
                            state_q <= ST_WAIT;
                            tmr_q   <= 24'd0;
                        end else begin
                            err_q   <= 3'd2;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        state_q <= ST_CSUM;
                    end
                end
                ST_WAIT: begin
                    // DONE is checked first so it wins over a coincident timeout
                    if (bus.AL_DONE) begin
                        state_q <= ST_CLEAR;
                        clr_q   <= 1'b1;
                    end else if (tmr_q == TMO_LAST) begin
                        err_q   <= 3'd3;
                        state_q <= ST_IDLE;
                    end else begin
                        tmr_q   <= tmr_q + 24'd1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_CLEAR: begin
                    ok_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.BPI_RD_REQ  = rd_req_q;
    assign bus.CAPTURE     = capture_q;
    assign bus.BPI_AL_REG  = al_reg_q;
    assign bus.CLR_AL_DONE = clr_q;
    assign bus.BUSY        = (state_q != ST_IDLE);
    assign bus.AL_OK       = ok_q;
    assign bus.AL_ERR      = err_q;
    assign bus.WORD_CNT    = cnt_q;

endmodule

// File: tb/tb_al_bky_word_sequencer.sv
// Directed bench: instance 0 (N_WORDS=4, default timeout) and instance 1
// (N_WORDS=4, TMO_CYC=50), each checked every cycle against an image-level model.
module tb_al_bky_word_sequencer;

    localparam int N_W = 4;
    localparam logic [15:0] HDR = 16'hBC0A;
    int tmo [2] = '{2000000, 50};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_r [2];
    logic        vld_r   [2];
    logic [15:0] data_r  [2];
    logic        done_r  [2];

    al_bky_word_sequencer_if ifa ();
    al_bky_word_sequencer_if ifb ();

    assign ifa.START = start_r[0];
    assign ifa.BPI_DATA_VLD = vld_r[0];
    assign ifa.BPI_DATA = data_r[0];
    assign ifa.AL_DONE = done_r[0];
    assign ifb.START = start_r[1];
    assign ifb.BPI_DATA_VLD = vld_r[1];
    assign ifb.BPI_DATA = data_r[1];
    assign ifb.AL_DONE = done_r[1];

    al_bky_word_sequencer #(.N_WORDS(16'd4), .HDR_WORD(16'hBC0A), .TMO_CYC(24'd2000000)) dut_a (
        .CLK40(clk), .RST_N(rst_n), .bus(ifa.master));
    al_bky_word_sequencer #(.N_WORDS(16'd4), .HDR_WORD(16'hBC0A), .TMO_CYC(24'd50)) dut_b (
        .CLK40(clk), .RST_N(rst_n), .bus(ifb.master));

    logic        o_req [2], o_cap [2], o_clr [2], o_busy [2], o_ok [2];
    logic [15:0] o_reg [2];
    logic [2:0]  o_err [2];
    logic [10:0] o_cnt [2];
    assign o_req[0] = ifa.BPI_RD_REQ;  assign o_req[1] = ifb.BPI_RD_REQ;
    assign o_cap[0] = ifa.CAPTURE;     assign o_cap[1] = ifb.CAPTURE;
    assign o_reg[0] = ifa.BPI_AL_REG;  assign o_reg[1] = ifb.BPI_AL_REG;
    assign o_clr[0] = ifa.CLR_AL_DONE; assign o_clr[1] = ifb.CLR_AL_DONE;
    assign o_busy[0] = ifa.BUSY;       assign o_busy[1] = ifb.BUSY;
    assign o_ok[0] = ifa.AL_OK;        assign o_ok[1] = ifb.AL_OK;
    assign o_err[0] = ifa.AL_ERR;      assign o_err[1] = ifb.AL_ERR;
    assign o_cnt[0] = ifa.WORD_CNT;    assign o_cnt[1] = ifb.WORD_CNT;

    int n_cmp = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Image-level model: a run is "active" from START until it ends; the image is
    // indexed by word position (0 = header, 1..N = payload, N+1 = checksum).
    bit          m_active [2], m_reqcyc [2], m_wait [2], m_clrcyc [2];
    int          m_idx [2], m_elapsed [2];
    logic [15:0] m_acc [2];
    logic        e_req [2], e_cap [2], e_clr [2], e_busy [2], e_ok [2];
    logic [15:0] e_reg [2];
    logic [2:0]  e_err [2];
    int          e_cnt [2];

    task automatic model_step(input int k);
        if (!rst_n) begin
            m_active[k] = 0; m_reqcyc[k] = 0; m_wait[k] = 0; m_clrcyc[k] = 0;
            m_idx[k] = 0; m_elapsed[k] = 0; m_acc[k] = 16'd0;
            e_req[k] = 0; e_cap[k] = 0; e_clr[k] = 0; e_busy[k] = 0; e_ok[k] = 0;
            e_reg[k] = 16'd0; e_err[k] = 3'd0; e_cnt[k] = 0;
            return;
        end
        e_req[k] = 0; e_cap[k] = 0; e_clr[k] = 0;
        if (!m_active[k]) begin
            if (start_r[k]) begin
                m_active[k] = 1; m_reqcyc[k] = 1; m_wait[k] = 0; m_clrcyc[k] = 0;
                m_idx[k] = 0; m_acc[k] = 16'd0;
                e_req[k] = 1; e_ok[k] = 0; e_err[k] = 3'd0; e_cnt[k] = 0;
            end
        end else if (m_reqcyc[k]) begin
            m_reqcyc[k] = 0;
        end else if (m_clrcyc[k]) begin
            m_clrcyc[k] = 0; m_active[k] = 0; e_ok[k] = 1;
        end else if (m_wait[k]) begin
            if (done_r[k]) begin
                m_wait[k] = 0; m_clrcyc[k] = 1; e_clr[k] = 1;
            end else if (m_elapsed[k] == tmo[k] - 1) begin
                m_wait[k] = 0; m_active[k] = 0; e_err[k] = 3'd3;
            end else begin
                m_elapsed[k]++;
            end
        end else if (vld_r[k]) begin
            if (m_idx[k] == 0) begin
                if (data_r[k] != HDR) begin
                    m_active[k] = 0; e_err[k] = 3'd1;
                end else begin
                    m_idx[k] = 1;
                end
            end else if (m_idx[k] <= N_W) begin
                e_cap[k] = 1; e_reg[k] = data_r[k];
                m_acc[k] = m_acc[k] ^ data_r[k];
                e_cnt[k]++; m_idx[k]++;
            end else if (data_r[k] == m_acc[k]) begin
                m_wait[k] = 1; m_elapsed[k] = 0;
            end else begin
                m_active[k] = 0; e_err[k] = 3'd2;
            end
        end
        e_busy[k] = m_active[k];
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        cmp_en <= 1'b1;
    end

    int req_cnt [2], clr_cnt [2], cap_cnt [2];
    logic [15:0] caps_a [$];

    // Per-cycle compare of both instances against the model, plus event tallies.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("BPI_RD_REQ[%0d]", k), o_req[k], e_req[k]);
                chk($sformatf("CAPTURE[%0d]", k), o_cap[k], e_cap[k]);
                chk($sformatf("BPI_AL_REG[%0d]", k), o_reg[k], e_reg[k]);
                chk($sformatf("CLR_AL_DONE[%0d]", k), o_clr[k], e_clr[k]);
                chk($sformatf("BUSY[%0d]", k), o_busy[k], e_busy[k]);
                chk($sformatf("AL_OK[%0d]", k), o_ok[k], e_ok[k]);
                chk($sformatf("AL_ERR[%0d]", k), o_err[k], e_err[k]);
                chk($sformatf("WORD_CNT[%0d]", k), o_cnt[k], e_cnt[k]);
                if (o_req[k] === 1'b1) req_cnt[k]++;
                if (o_clr[k] === 1'b1) clr_cnt[k]++;
                if (o_cap[k] === 1'b1) cap_cnt[k]++;
            end
            if (o_cap[0] === 1'b1) caps_a.push_back(o_reg[0]);
        end
    end

    task automatic clear_tally();
        for (int k = 0; k < 2; k++) begin
            req_cnt[k] = 0; clr_cnt[k] = 0; cap_cnt[k] = 0;
        end
        caps_a.delete();
    endtask

    task automatic pulse_start(input int k);
        start_r[k] = 1'b1;
        @(negedge clk);
        start_r[k] = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input int k, input logic [15:0] w, input int gap, input bit noise);
        vld_r[k] = 1'b1; data_r[k] = w; start_r[k] = noise;
        @(negedge clk);
        vld_r[k] = 1'b0; start_r[k] = 1'b0;
        for (int g = 0; g < gap; g++) begin
            start_r[k] = noise;
            @(negedge clk);
            start_r[k] = 1'b0;
        end
    endtask

    task automatic send_image(input int k, input logic [15:0] csum, input int gap, input bit noise);
        logic [15:0] img [6];
        img = '{16'hBC0A, 16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0000};
        img[5] = csum;
        for (int i = 0; i < 6; i++) send(k, img[i], gap, noise);
    endtask

    task automatic finish_done(input int k, input int delay);
        repeat (delay) @(negedge clk);
        done_r[k] = 1'b1;
        repeat (3) @(negedge clk);
        done_r[k] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_t1_result(input string tag);
        logic [15:0] exp_caps [4];
        exp_caps = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};
        chk({tag, "_caps"}, caps_a.size(), 4);
        for (int i = 0; i < 4 && i < caps_a.size(); i++)
            chk($sformatf("%s_cap%0d", tag, i), caps_a[i], exp_caps[i]);
        chk({tag, "_req"}, req_cnt[0], 1);
        chk({tag, "_clr"}, clr_cnt[0], 1);
        chk({tag, "_ok"}, o_ok[0], 1);
        chk({tag, "_err"}, o_err[0], 0);
        chk({tag, "_cnt"}, o_cnt[0], 4);
        chk({tag, "_busy"}, o_busy[0], 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            start_r[k] = 1'b0; vld_r[k] = 1'b0; data_r[k] = 16'd0; done_r[k] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", o_busy[0], 0);
        chk("reset_reg", o_reg[0], 0);
        chk("reset_err", o_err[1], 0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: clean run, DONE after 100 cycles
        clear_tally();
        pulse_start(0);
        send_image(0, 16'h000F, 0, 1'b0);
        finish_done(0, 100);
        check_t1_result("t1");

        // T2: bad header
        clear_tally();
        pulse_start(0);
        send(0, 16'h1234, 0, 1'b0);
        chk("t2_busy", o_busy[0], 0);
        chk("t2_err", o_err[0], 1);
        repeat (3) @(negedge clk);
        chk("t2_caps", cap_cnt[0], 0);
        chk("t2_clr", clr_cnt[0], 0);

        // T3: bad checksum
        clear_tally();
        pulse_start(0);
        send_image(0, 16'h000E, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("t3_caps", cap_cnt[0], 4);
        chk("t3_err", o_err[0], 2);
        chk("t3_ok", o_ok[0], 0);
        chk("t3_clr", clr_cnt[0], 0);

        // T4a: instance 1 times out exactly 50 cycles after WAIT_DONE entry
        clear_tally();
        pulse_start(1);
        send_image(1, 16'h000F, 0, 1'b0);
        repeat (49) @(negedge clk);
        chk("t4_err_pre", o_err[1], 0);
        chk("t4_busy_pre", o_busy[1], 1);
        @(negedge clk);
        chk("t4_err_tmo", o_err[1], 3);
        chk("t4_busy_tmo", o_busy[1], 0);
        chk("t4_clr_tmo", clr_cnt[1], 0);

        // T4b: DONE on the final cycle wins over the timeout
        clear_tally();
        pulse_start(1);
        send_image(1, 16'h000F, 0, 1'b0);
        repeat (49) @(negedge clk);
        done_r[1] = 1'b1;
        @(negedge clk);
        chk("t4_clr_edge", o_clr[1], 1);
        chk("t4_err_edge", o_err[1], 0);
        done_r[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_ok", o_ok[1], 1);

        // T5: gapped valids with START noise while busy
        clear_tally();
        pulse_start(0);
        send_image(0, 16'h000F, 2, 1'b1);
        finish_done(0, 10);
        check_t1_result("t5");

        // T6: reset after two payload words, then a clean rerun
        clear_tally();
        pulse_start(0);
        send(0, 16'hBC0A, 0, 1'b0);
        send(0, 16'h0001, 0, 1'b0);
        send(0, 16'h0002, 0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_busy", o_busy[0], 0);
        chk("t6_reg", o_reg[0], 0);
        chk("t6_cnt", o_cnt[0], 0);
        chk("t6_cap", o_cap[0], 0);
        rst_n = 1'b1;
        @(negedge clk);
        clear_tally();
        pulse_start(0);
        send_image(0, 16'h000F, 0, 1'b0);
        finish_done(0, 20);
        check_t1_result("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
